// File: rtl/motor_arbiter.sv
// motor_arbiter: fixed-priority stop/avoid/line-follow H-bridge arbiter with reversal dead time.
// Define MOTOR_ARB_PWM_EN to gate motor_en in DRIVE with a duty-cycle PWM.
module motor_arbiter #(
  parameter int DEADTIME_CYC = 1000,
  parameter int PWM_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stop_req,
  input  logic             av_req,
  input  logic [3:0]       av_cmd,
  input  logic             lf_req,
  input  logic [3:0]       lf_cmd,
  input  logic [PWM_W-1:0] duty,
  output logic [3:0]       motor_in,
  output logic [1:0]       motor_en,
  output logic [1:0]       grant,
  output logic             busy
);
  localparam int CW = $clog2(DEADTIME_CYC + 1);
  typedef enum logic [1:0] {IDLE, DRIVE, DEAD, STOP} state_t;
  state_t state_q, state_d;
  logic [3:0] last_q, last_d, mi_q, mi_d, raw, cand;
  logic [1:0] en_q, en_d, grant_q, grant_d, win;
  logic busy_q, busy_d, rev;
  logic [CW-1:0] cnt_q, cnt_d;
  assign win  = stop_req ? 2'b11 : av_req ? 2'b10 : lf_req ? 2'b01 : 2'b00;
  assign raw  = av_req ? av_cmd : lf_req ? lf_cmd : 4'b0000;
  assign cand = {raw[3:2] == 2'b11 ? 2'b00 : raw[3:2], raw[1:0] == 2'b11 ? 2'b00 : raw[1:0]};
  // A half reverses only if it was actively driven and the candidate is its complement.
  assign rev  = ((last_q[3] ^ last_q[2]) && cand[3:2] == ~last_q[3:2]) ||
                ((last_q[1] ^ last_q[0]) && cand[1:0] == ~last_q[1:0]);
  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    last_d  = last_q;
    grant_d = grant_q;
    if (stop_req) begin
      state_d = STOP;
      grant_d = 2'b11;
    end else if (state_q == DEAD && cnt_q > CW'(1)) begin
      cnt_d = cnt_q - CW'(1);
    end else if (win == 2'b00) begin
      state_d = IDLE;
      grant_d = 2'b00;
    end else if (state_q != DEAD && rev) begin
      state_d = DEAD;
      cnt_d   = CW'(DEADTIME_CYC);
      grant_d = win;
    end else begin
      state_d = DRIVE;
      last_d  = cand;
      grant_d = win;
    end
    mi_d   = state_d == DRIVE ? cand : 4'b0000;
    busy_d = state_d == DEAD;
  end
`ifdef MOTOR_ARB_PWM_EN
  logic [PWM_W-1:0] pwm_q, pwm_d;
  assign pwm_d = pwm_q + 1'b1;
  assign en_d  = (state_d == DRIVE && pwm_q < duty) ? 2'b11 : 2'b00;
  always_ff @(posedge clk or posedge rst)
    if (rst) pwm_q <= '0;
    else     pwm_q <= pwm_d;
`else
  logic unused_duty;
  assign unused_duty = ^duty;
  assign en_d = state_d == DRIVE ? 2'b11 : 2'b00;
`endif
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      last_q  <= '0;
      mi_q    <= '0;
      en_q    <= '0;
      grant_q <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      mi_q    <= mi_d;
      en_q    <= en_d;
      grant_q <= grant_d;
      busy_q  <= busy_d;
    end
  end
  assign motor_in = mi_q;
  assign motor_en = en_q;
  assign grant    = grant_q;
  assign busy     = busy_q;
endmodule

// File: doc/motor_arbiter.md
MOTOR_ARBITER -- requirements
Module: motor_arbiter

Interface
REQ-001 SHALL have parameter DEADTIME_CYC, default 1000, meaning the number of de-energized cycles inserted on any motor-half reversal (minimum 1).
REQ-002 SHALL have parameter PWM_W, default 8, meaning the width of the PWM counter and of duty.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port stop_req  input  1  colour-stop request (red line), highest priority.
REQ-006 SHALL have port av_req  input  1  obstacle-avoidance (proximity) request, middle priority.
REQ-007 SHALL have port av_cmd  input  4  avoidance motor command, {left[1:0], right[1:0]}.
REQ-008 SHALL have port lf_req  input  1  line-follower request, lowest priority.
REQ-009 SHALL have port lf_cmd  input  4  line-follower motor command, same encoding as av_cmd.
REQ-010 SHALL have port duty  input  PWM_W  PWM on-time; sampled every cycle.
REQ-011 SHALL have port motor_in  output  4  registered H-bridge direction bits.
REQ-012 SHALL have port motor_en  output  2  registered H-bridge enables {left, right}.
REQ-013 SHALL have port grant  output  2  00 none, 01 lf, 10 av, 11 stop.
REQ-014 SHALL have port busy  output  1  high while in DEAD.

Function
REQ-015 SHALL implement the states IDLE, DRIVE, DEAD and STOP.
REQ-016 SHALL arbitrate each cycle with fixed priority stop_req > av_req > lf_req; the winner's cmd is the candidate.
REQ-017 SHALL replace an illegal half value 2'b11 in a candidate with 2'b00 (coast) before any use.
REQ-018 SHALL hold last_cmd, the most recently applied command; a reversal exists when any half of last_cmd is 01 or 10 and the same half of the candidate is its complement.
REQ-019 SHALL have a latency of one cycle: request/cmd seen at edge N is reflected on the outputs after edge N+1.
REQ-020 SHALL in IDLE (no request) drive motor_in=0000, motor_en=00, grant=00, and retain last_cmd.
REQ-021 SHALL, from IDLE or DRIVE, on a candidate without reversal enter/stay in DRIVE: motor_in=candidate, last_cmd=candidate, grant=winner.
REQ-022 SHALL, from IDLE or DRIVE, on a candidate with reversal enter DEAD: motor_in=0000, motor_en=00, busy=1, and load the dead counter with DEADTIME_CYC.
REQ-023 SHALL, in DEAD, decrement the counter each cycle; on the cycle it reaches 0 re-arbitrate and go to DRIVE with no reversal check (last_cmd := new candidate), or to IDLE if no request.
REQ-024 SHALL keep grant equal to the requester that caused DEAD until DEAD exits; requester changes during DEAD shall not restart the counter.
REQ-025 SHALL enter STOP the cycle after stop_req is seen from any state, including aborting DEAD (counter cleared): motor_in=0000, motor_en=00, grant=11.
REQ-026 SHALL, on stop_req release, apply REQ-020..022 against the retained last_cmd.
REQ-027 SHALL, in DRIVE, run a free-running PWM_W-bit counter wrapping from all-ones to 0 and drive motor_en=11 when counter < duty, else 00; duty=0 means always off, and all-ones duty means off for one cycle per period.
REQ-028 SHALL force motor_en=00 in IDLE, DEAD and STOP regardless of duty.

Reset
REQ-029 SHALL, on rst high, immediately (asynchronously) force state=IDLE, motor_in=0000, motor_en=00, grant=00, busy=0, last_cmd=0000, dead counter=0, PWM counter=0.
REQ-030 SHALL, on rst assertion mid-DEAD or mid-DRIVE, discard all pending state; the first post-reset command shall incur no dead time.

Configuration
REQ-031 SHALL, when macro MOTOR_ARB_PWM_EN is defined, implement REQ-027 PWM gating.
REQ-032 SHALL, when MOTOR_ARB_PWM_EN is undefined, drive motor_en=11 throughout DRIVE, ignore duty and omit the PWM counter; all other behaviour shall be unchanged.

Verification
REQ-033 SHALL verify: lf_req=1, lf_cmd=0101 after reset -> motor_in=0101, grant=01 one cycle later, with no DEAD.
REQ-034 SHALL verify: lf_cmd 0101, then av_req=1 with av_cmd=1010 -> DEAD with busy=1 and motor_en=00 for exactly DEADTIME_CYC cycles, then motor_in=1010, grant=10.
REQ-035 SHALL verify: stop_req pulsed mid-DEAD -> STOP and grant=11 next cycle; on release with lf_cmd=0101 and last_cmd=0101 -> DRIVE, no DEAD.
REQ-036 SHALL verify: lf_cmd=1101 -> motor_in=0001 (left half coasted).
REQ-037 SHALL verify: with PWM_EN defined, PWM_W=8 and duty=64, DRIVE -> motor_en=11 for 64 of every 256 cycles; with duty=0 -> always 00; with the macro undefined -> constant 11.
REQ-038 SHALL verify: rst asserted between clock edges during DRIVE -> all outputs 0 before the next edge.
